// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences shift instructions through LOAD, SHIFT and WRITE with registered controls.
module shift_seq_ctrl (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       is_lui,
  input  logic [5:0] funct,
  output logic [1:0] ShiftSrc,
  output logic [1:0] ShamtSrc,
  output logic [2:0] ShiftCtl,
  output logic       wr_en,
  output logic       busy,
  output logic       done,
  output logic       bad_funct,
  output logic [7:0] op_count
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, WRITE} state_t;
  state_t      state_q;
  logic [1:0]  src_q, amt_q, src_d, amt_d;
  logic [2:0]  ctl_q, dir_q, dir_d;
  logic        wr_q, done_q, busy_q, bad_q, legal;
  logic [7:0]  cnt_q;
  assign legal = is_lui | (funct inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07});
  assign dir_d = is_lui ? 3'b010 : funct[1:0] == 2'b00 ? 3'b010 : funct[1:0] == 2'b10 ? 3'b011 : 3'b100;
  assign src_d = is_lui ? 2'b10 : 2'b01;
  assign amt_d = is_lui ? 2'b10 : {1'b0, funct[2]};
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      amt_q   <= '0;
      ctl_q   <= '0;
      dir_q   <= '0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      bad_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bad_q <= 1'b0;
      case (state_q)
        IDLE: begin
          bad_q <= start & ~legal;
          if (start && legal) begin
            state_q <= LOAD;
            src_q   <= src_d;
            amt_q   <= amt_d;
            dir_q   <= dir_d;
            ctl_q   <= 3'b001;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= SHIFT;
          ctl_q   <= dir_q;
        end
        SHIFT: begin
          state_q <= WRITE;
          ctl_q   <= 3'b000;
          wr_q    <= 1'b1;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          wr_q    <= 1'b0;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          src_q   <= '0;
          amt_q   <= '0;
          cnt_q   <= cnt_q + 8'd1;
        end
      endcase
    end
  end
  assign ShiftSrc  = src_q;
  assign ShamtSrc  = amt_q;
  assign ShiftCtl  = ctl_q;
  assign wr_en     = wr_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign bad_funct = bad_q;
  assign op_count  = cnt_q;
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: random and directed stimulus against a transaction-level reference model.
module tb_shift_seq_ctrl;
  logic       clock = 1'b0;
  logic       reset, start, is_lui;
  logic [5:0] funct;
  logic [1:0] ShiftSrc, ShamtSrc;
  logic [2:0] ShiftCtl;
  logic       wr_en, busy, done, bad_funct;
  logic [7:0] op_count;
  int n_cmp = 0, n_bad = 0;
  int phase = 0, op = 0, m_cnt = 0;
  bit m_bad = 0;
  int dir_tab[7] = '{2, 3, 4, 2, 3, 4, 2};

  shift_seq_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .is_lui(is_lui), .funct(funct),
    .ShiftSrc(ShiftSrc), .ShamtSrc(ShamtSrc), .ShiftCtl(ShiftCtl), .wr_en(wr_en),
    .busy(busy), .done(done), .bad_funct(bad_funct), .op_count(op_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // op index: 0 sll, 1 srl, 2 sra, 3 sllv, 4 srlv, 5 srav, 6 lui; -1 rejected
  function automatic int decode(input bit l, input bit [5:0] f);
    if (l) return 6;
    case (f)
      6'h00: return 0;
      6'h02: return 1;
      6'h03: return 2;
      6'h04: return 3;
      6'h06: return 4;
      6'h07: return 5;
      default: return -1;
    endcase
  endfunction

  task automatic cyc(input bit r, input bit s, input bit l, input bit [5:0] f);
    int d;
    reset = r; start = s; is_lui = l; funct = f;
    @(posedge clock);
    if (r) begin
      phase = 0; m_bad = 0; m_cnt = 0;
    end else begin
      m_bad = 0;
      if (phase == 0) begin
        if (s) begin
          d = decode(l, f);
          if (d < 0) m_bad = 1;
          else begin phase = 1; op = d; end
        end
      end else if (phase == 3) begin
        phase = 0;
        m_cnt = (m_cnt + 1) % 256;
      end else phase++;
    end
    @(negedge clock);
    chk("busy", 8'(busy), 8'(phase != 0));
    chk("ShiftSrc", 8'(ShiftSrc), 8'(phase == 0 ? 0 : op == 6 ? 2 : 1));
    chk("ShamtSrc", 8'(ShamtSrc), 8'(phase == 0 ? 0 : op == 6 ? 2 : (op >= 3 ? 1 : 0)));
    chk("ShiftCtl", 8'(ShiftCtl), 8'(phase == 1 ? 1 : phase == 2 ? dir_tab[op] : 0));
    chk("wr_en", 8'(wr_en), 8'(phase == 3));
    chk("done", 8'(done), 8'(phase == 3));
    chk("bad_funct", 8'(bad_funct), 8'(m_bad));
    chk("op_count", op_count, 8'(m_cnt));
  endtask

  initial begin
    bit [5:0] f;
    cyc(1, 1, 0, 6'h03);
    cyc(1, 0, 0, 6'h00);
    cyc(0, 1, 0, 6'h03);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'h00);
    cyc(0, 1, 1, 6'h3F);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'h00);
    cyc(0, 1, 0, 6'h05);
    cyc(0, 1, 0, 6'h02);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 6'h00);
    cyc(0, 1, 0, 6'h04);
    cyc(0, 1, 0, 6'h02);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 6'h02);
    cyc(0, 0, 0, 6'h00);
    cyc(0, 1, 0, 6'h07);
    cyc(0, 0, 0, 6'h00);
    cyc(1, 1, 0, 6'h07);
    cyc(0, 0, 0, 6'h00);
    chk("op_count_after_reset", op_count, 8'd0);
    for (int i = 0; i < 1040; i++) cyc(0, 1, 1, 6'h00);
    chk("op_count_wrapped", op_count, 8'(m_cnt));
    for (int i = 0; i < 3000; i++) begin
      f = ($urandom_range(0, 9) > 7) ? 6'($urandom) : 6'($urandom_range(0, 7));
      cyc($urandom_range(0, 99) < 3, $urandom_range(0, 1), $urandom_range(0, 4) == 0, f);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have port: clock  in  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: start  in  1  shift-instruction request from main control; sampled only in IDLE.
REQ-004 SHALL have port: is_lui  in  1  request is LUI (immediate << 16); qualified by start.
REQ-005 SHALL have port: funct  in  6  R-type funct; valid with start when is_lui=0.
REQ-006 SHALL have port: ShiftSrc  out  2  shift-value mux select: 00 regA, 01 regB, 10 immediate.
REQ-007 SHALL have port: ShamtSrc  out  2  shift-amount select: 00 shamt field, 01 regA[4:0], 10 constant 16.
REQ-008 SHALL have port: ShiftCtl  out  3  shifter command: 000 nop, 001 load, 010 sll, 011 srl, 100 sra.
REQ-009 SHALL have port: wr_en  out  1  register-file write of shifter result.
REQ-010 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port: done  out  1  one-cycle completion pulse.
REQ-012 SHALL have port: bad_funct  out  1  one-cycle pulse on rejected request.
REQ-013 SHALL have port: op_count  out  8  count of completed operations.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, SHIFT, WRITE; single state register.
REQ-015 SHALL accept a request when start=1 in IDLE and the operation is legal; next state LOAD.
REQ-016 SHALL decode legal operations: is_lui=1 -> LUI; else funct 0x00 sll, 0x02 srl, 0x03 sra, 0x04 sllv, 0x06 srlv, 0x07 srav.
REQ-017 SHALL give is_lui priority over funct; funct is ignored when is_lui=1.
REQ-018 SHALL latch the decoded operation at acceptance; input changes after acceptance have no effect.
REQ-019 SHALL drive ShiftSrc/ShamtSrc from the latched operation, constant across LOAD, SHIFT, WRITE: sll/srl/sra -> 01/00; sllv/srlv/srav -> 01/01; LUI -> 10/10.
REQ-020 SHALL drive ShiftCtl=001 in LOAD, the direction code in SHIFT (LUI uses 010), and 000 in IDLE and WRITE.
REQ-021 SHALL sequence LOAD -> SHIFT -> WRITE -> IDLE unconditionally, one cycle each.
REQ-022 SHALL assert wr_en and done only during WRITE: accept at edge N gives done high for cycle N+3 and next accept no earlier than edge N+4.
REQ-023 SHALL ignore start while busy; there is no queueing.
REQ-024 SHALL, on start=1 in IDLE with illegal funct and is_lui=0, stay in IDLE, pulse bad_funct for exactly the next cycle, and keep ShiftCtl=000.
REQ-025 SHALL drive ShiftSrc=00, ShamtSrc=00, wr_en=0, done=0 in IDLE.
REQ-026 SHALL increment op_count by 1 on each WRITE cycle, wrapping 255 -> 0; rejected requests do not count.
REQ-027 SHALL derive all outputs registered or from the state register only (no combinational path from start/funct to outputs).

Reset
REQ-028 SHALL, with reset=1 at a rising edge, enter IDLE and set ShiftSrc=00, ShamtSrc=00, ShiftCtl=000, wr_en=0, busy=0, done=0, bad_funct=0, op_count=0.
REQ-029 SHALL give reset priority over start and over any in-flight operation; reset during LOAD/SHIFT/WRITE aborts without wr_en or done.
REQ-030 SHALL ignore start in the cycle reset is asserted.

Verification
REQ-031 SHALL pass: start=1, funct=0x03 in IDLE -> LOAD ShiftCtl=001, SHIFT ShiftCtl=100, WRITE wr_en=1 done=1, ShiftSrc=01 ShamtSrc=00 throughout, op_count 0->1.
REQ-032 SHALL pass: start=1, is_lui=1, funct=0x3F -> ShiftSrc=10, ShamtSrc=10, SHIFT ShiftCtl=010, no bad_funct.
REQ-033 SHALL pass: start=1, funct=0x05 -> bad_funct one cycle, busy=0, op_count unchanged, next legal start accepted the following cycle.
REQ-034 SHALL pass: start held high across sllv then funct changed to srl during LOAD -> sllv completes (ShamtSrc=01), srl accepted only after return to IDLE.
REQ-035 SHALL pass: reset asserted in SHIFT -> next cycle IDLE, all outputs zero, no wr_en/done pulse.
REQ-036 SHALL pass: 256 completed ops -> op_count wraps to 0.
